// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory arbiter: access sizes, FSM states and the
// access-size to beat-count mapping.
package mem_arb_pkg;

  localparam logic [1:0] ACC_1W  = 2'b00;
  localparam logic [1:0] ACC_4W  = 2'b01;
  localparam logic [1:0] ACC_8W  = 2'b10;
  localparam logic [1:0] ACC_16W = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_XFER  = 2'b01,
    ST_DRAIN = 2'b10
  } arb_state_t;

  function automatic logic [4:0] beat_count(input logic [1:0] size);
    logic [4:0] n;
    case (size)
      ACC_1W:  n = 5'd1;
      ACC_4W:  n = 5'd4;
      ACC_8W:  n = 5'd8;
      ACC_16W: n = 5'd16;
      default: n = 5'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way request picker for the memory arbiter. With ARB_ROUND_ROBIN_EN
// defined it alternates on contention; otherwise dm has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
  input  logic clock,
  input  logic reset,
  input  logic update,
`endif
  input  logic if_req,
  input  logic dm_req,
  output logic gnt_if,
  output logic gnt_dm
);

  logic prefer_dm_s;

`ifdef ARB_ROUND_ROBIN_EN
  logic prefer_dm_r;

  // Favour the port that was not granted last; dm is favoured out of reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      prefer_dm_r <= 1'b1;
    end else if (update) begin
      prefer_dm_r <= gnt_if;
    end
  end

  assign prefer_dm_s = prefer_dm_r;
`else
  assign prefer_dm_s = 1'b1;
`endif

  // One-hot grant; a lone requester always wins regardless of preference.
  always_comb begin
    gnt_dm = 1'b0;
    gnt_if = 1'b0;
    if (dm_req && (prefer_dm_s || !if_req)) begin
      gnt_dm = 1'b1;
    end else if (if_req) begin
      gnt_if = 1'b1;
    end else begin
      gnt_dm = 1'b0;
      gnt_if = 1'b0;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one single-port memory between instruction fetch and data access,
// sequencing 1/4/8/16-word bursts. Optional macro: ARB_ROUND_ROBIN_EN.
module memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic [1:0]        if_size,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic              if_done,
  input  logic              dm_req,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [1:0]        dm_size,
  input  logic              dm_rw,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_wready,
  output logic              dm_rvalid,
  output logic              dm_done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic [1:0]        mem_access_size,
  output logic              mem_rw,
  output logic              mem_enable,
  input  logic              mem_busy,
  input  logic [DATA_W-1:0] mem_data_out
);

  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  arb_state_t        state_r;
  logic              owner_dm_r;
  logic [4:0]        beats_left_r;
  logic [ADDR_W-1:0] mem_address_r;
  logic [1:0]        mem_access_size_r;
  logic              mem_rw_r;
  logic              mem_enable_r;
  logic              if_gnt_r, dm_gnt_r;
  logic              if_rvalid_r, dm_rvalid_r;
  logic              if_done_r, dm_done_r;
  logic [DATA_W-1:0] rdata_r;

  logic start_s, pick_if_s, pick_dm_s, accept_s, write_phase_s;

  assign start_s       = (state_r == ST_IDLE) && !mem_busy && (if_req || dm_req);
  assign accept_s      = (state_r == ST_XFER) && !mem_busy;
  assign write_phase_s = (state_r == ST_XFER) && !mem_rw_r;

  mem_arb_pick u_pick (
`ifdef ARB_ROUND_ROBIN_EN
    .clock  (clock),
    .reset  (reset),
    .update (start_s),
`endif
    .if_req (if_req),
    .dm_req (dm_req),
    .gnt_if (pick_if_s),
    .gnt_dm (pick_dm_s)
  );

  // Transaction sequencer: latch request in IDLE, step beats in XFER, signal done in DRAIN.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r           <= ST_IDLE;
      owner_dm_r        <= 1'b0;
      beats_left_r      <= 5'd0;
      mem_address_r     <= '0;
      mem_access_size_r <= 2'b00;
      mem_rw_r          <= 1'b0;
      mem_enable_r      <= 1'b0;
      if_gnt_r          <= 1'b0;
      dm_gnt_r          <= 1'b0;
      if_rvalid_r       <= 1'b0;
      dm_rvalid_r       <= 1'b0;
      if_done_r         <= 1'b0;
      dm_done_r         <= 1'b0;
      rdata_r           <= '0;
    end else begin
      if_gnt_r    <= 1'b0;
      dm_gnt_r    <= 1'b0;
      if_rvalid_r <= 1'b0;
      dm_rvalid_r <= 1'b0;
      if_done_r   <= 1'b0;
      dm_done_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r           <= ST_XFER;
            owner_dm_r        <= pick_dm_s;
            if_gnt_r          <= pick_if_s;
            dm_gnt_r          <= pick_dm_s;
            mem_enable_r      <= 1'b1;
            // Fetches are always reads.
            mem_rw_r          <= pick_dm_s ? dm_rw : 1'b1;
            mem_access_size_r <= pick_dm_s ? dm_size : if_size;
            mem_address_r     <= (pick_dm_s ? dm_addr : if_addr) & WORD_MASK;
            beats_left_r      <= beat_count(pick_dm_s ? dm_size : if_size) - 5'd1;
          end
        end
        ST_XFER: begin
          if (accept_s) begin
            if (mem_rw_r) begin
              rdata_r     <= mem_data_out;
              if_rvalid_r <= !owner_dm_r;
              dm_rvalid_r <= owner_dm_r;
            end
            if (beats_left_r == 5'd0) begin
              state_r      <= ST_DRAIN;
              mem_enable_r <= 1'b0;
              if_done_r    <= !owner_dm_r;
              dm_done_r    <= owner_dm_r;
            end else begin
              beats_left_r  <= beats_left_r - 5'd1;
              mem_address_r <= mem_address_r + ADDR_W'(4);
            end
          end
        end
        ST_DRAIN: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r      <= ST_IDLE;
          mem_enable_r <= 1'b0;
        end
      endcase
    end
  end

  // Write data passes straight through so the memory sees it with the beat it belongs to.
  always_comb begin
    if (write_phase_s) begin
      mem_data_in = dm_wdata;
    end else begin
      mem_data_in = '0;
    end
    dm_wready = write_phase_s && !mem_busy;
  end

  assign if_gnt          = if_gnt_r;
  assign dm_gnt          = dm_gnt_r;
  assign if_rvalid       = if_rvalid_r;
  assign dm_rvalid       = dm_rvalid_r;
  assign if_done         = if_done_r;
  assign dm_done         = dm_done_r;
  assign rdata           = rdata_r;
  assign mem_address     = mem_address_r;
  assign mem_access_size = mem_access_size_r;
  assign mem_rw          = mem_rw_r;
  assign mem_enable      = mem_enable_r;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus randomized
// bursts checked against a transaction-level model of addresses and read data.
module tb_memory_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req, dm_req, dm_rw, mem_busy;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_data_out;
  logic [1:0]  if_size, dm_size;
  logic        if_gnt, if_rvalid, if_done, dm_gnt, dm_wready, dm_rvalid, dm_done;
  logic [31:0] rdata, mem_address, mem_data_in;
  logic [1:0]  mem_access_size;
  logic        mem_rw, mem_enable;

  int checks = 0;
  int errors = 0;
  int wtab[4] = '{1, 4, 8, 16};

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  memory_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_size(if_size),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_done(if_done),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_size(dm_size), .dm_rw(dm_rw),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_wready(dm_wready),
    .dm_rvalid(dm_rvalid), .dm_done(dm_done), .rdata(rdata),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_access_size(mem_access_size), .mem_rw(mem_rw), .mem_enable(mem_enable),
    .mem_busy(mem_busy), .mem_data_out(mem_data_out)
  );

  always #5 clock = ~clock;

  // Memory content is a fixed function of the address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h1357};
  endfunction

  assign mem_data_out = mem_fn(mem_address);

  task automatic test_reset();
    logic [106:0] outs;
    reset = 1'b1; if_req = 1'b1; dm_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); #1;
      outs = {if_gnt, if_rvalid, if_done, dm_gnt, dm_wready, dm_rvalid, dm_done,
              rdata, mem_address, mem_data_in, mem_access_size, mem_rw, mem_enable};
      checks++;
      if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", outs); end
    end
    if_req = 1'b0; dm_req = 1'b0; reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); #1;
      checks++;
      if (mem_enable !== 1'b0 || if_gnt !== 1'b0 || dm_gnt !== 1'b0) begin
        errors++; $display("FAIL idle_no_req: en=%b if_gnt=%b dm_gnt=%b want 0 0 0", mem_enable, if_gnt, dm_gnt);
      end
    end
  endtask

  task automatic test_single_fetch();
    logic [31:0] a;
    a = 32'h8002_0000;
    @(negedge clock);
    if_req = 1'b1; if_addr = a; if_size = 2'b00; mem_busy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock); #1;
      checks++;
      if (if_gnt !== 1'b0 || mem_enable !== 1'b0) begin
        errors++; $display("FAIL busy_idle: if_gnt=%b en=%b want 0 0", if_gnt, mem_enable);
      end
    end
    mem_busy = 1'b0;
    @(negedge clock); #1;
    checks++;
    if (if_gnt !== 1'b1 || mem_address !== a || mem_rw !== 1'b1 || mem_enable !== 1'b1 || if_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_gnt: gnt=%b addr=%h rw=%b en=%b rv=%b want 1 %h 1 1 0", if_gnt, mem_address, mem_rw, mem_enable, if_rvalid, a);
    end
    if_req = 1'b0;
    @(negedge clock); #1;
    checks++;
    if (if_rvalid !== 1'b1 || if_done !== 1'b1 || rdata !== mem_fn(a) || mem_enable !== 1'b0) begin
      errors++;
      $display("FAIL fetch_data: rv=%b done=%b rdata=%h en=%b want 1 1 %h 0", if_rvalid, if_done, rdata, mem_enable, mem_fn(a));
    end
    @(negedge clock); #1;
    checks++;
    if (if_done !== 1'b0 || if_rvalid !== 1'b0) begin
      errors++; $display("FAIL fetch_pulse: done=%b rv=%b want 0 0", if_done, if_rvalid);
    end
  endtask

  // Runs one transaction on one port and checks every beat against the burst model.
  task automatic run_txn(input bit dm, input bit rw_in, input logic [31:0] base, input logic [1:0] size,
                         input int busy_pct, input int busy_beat, input int busy_len);
    logic [31:0] q[$];
    logic [31:0] exp_d, exp_a;
    int nb, k, left;
    bit got, exp_rv, exp_done, acc, fin, o_gnt, o_rv, o_done;
    logic [2:0] other;
    nb = wtab[size]; k = 0; left = busy_len;
    got = 1'b0; exp_rv = 1'b0; exp_done = 1'b0; fin = 1'b0;
    @(negedge clock);
    mem_busy = 1'b0;
    if (dm) begin
      dm_req = 1'b1; dm_addr = base | 32'($urandom_range(3)); dm_size = size; dm_rw = rw_in;
    end else begin
      if_req = 1'b1; if_addr = base | 32'($urandom_range(3)); if_size = size;
    end
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      @(negedge clock);
      mem_busy = 1'b0;
      if (got && k == busy_beat && left > 0) begin
        mem_busy = 1'b1; left--;
      end else if (got && $urandom_range(99) < busy_pct) begin
        mem_busy = 1'b1;
      end
      dm_wdata = $urandom;
      #1;
      o_gnt  = dm ? dm_gnt : if_gnt;
      o_rv   = dm ? dm_rvalid : if_rvalid;
      o_done = dm ? dm_done : if_done;
      other  = dm ? {if_gnt, if_rvalid, if_done} : {dm_gnt, dm_rvalid, dm_done};
      checks++;
      if (other !== 3'b000) begin errors++; $display("FAIL other_port: got %b want 000", other); end
      if (!got) begin
        if (o_gnt === 1'b1) begin
          got = 1'b1;
          if (dm) dm_req = 1'b0; else if_req = 1'b0;
        end else begin
          checks++;
          if (mem_enable !== 1'b0) begin errors++; $display("FAIL enable_before_gnt: got %b want 0", mem_enable); end
        end
      end else begin
        checks++;
        if (o_gnt !== 1'b0) begin errors++; $display("FAIL gnt_pulse: got %b want 0", o_gnt); end
      end
      acc = 1'b0;
      if (got && k < nb) begin
        exp_a = base + 32'(4 * k);
        checks++;
        if (mem_enable !== 1'b1 || mem_address !== exp_a || mem_rw !== rw_in || mem_access_size !== size) begin
          errors++;
          $display("FAIL beat_addr: got en=%b addr=%h rw=%b size=%b want 1 %h %b %b", mem_enable, mem_address, mem_rw, mem_access_size, exp_a, rw_in, size);
        end
        acc = !mem_busy;
        checks++;
        if (!rw_in) begin
          if (dm_wready !== acc || (acc && mem_data_in !== dm_wdata)) begin
            errors++; $display("FAIL wr_beat: got wready=%b data=%h want %b %h", dm_wready, mem_data_in, acc, dm_wdata);
          end
        end else if (dm_wready !== 1'b0) begin
          errors++; $display("FAIL wready_on_read: got %b want 0", dm_wready);
        end
        if (acc && rw_in) q.push_back(mem_fn(exp_a));
      end else if (got) begin
        checks++;
        if (mem_enable !== 1'b0) begin errors++; $display("FAIL enable_after_last: got %b want 0", mem_enable); end
      end
      checks++;
      if (o_rv !== exp_rv) begin errors++; $display("FAIL rvalid_timing: got %b want %b (beat %0d)", o_rv, exp_rv, k); end
      if (exp_rv && o_rv === 1'b1 && q.size() > 0) begin
        exp_d = q.pop_front();
        checks++;
        if (rdata !== exp_d) begin errors++; $display("FAIL rdata: got %h want %h", rdata, exp_d); end
      end
      checks++;
      if (o_done !== exp_done) begin errors++; $display("FAIL done_timing: got %b want %b (beat %0d of %0d)", o_done, exp_done, k, nb); end
      if (exp_done) fin = 1'b1;
      exp_rv   = acc && rw_in;
      exp_done = acc && (k + 1 == nb);
      if (acc) k++;
    end
    if (!fin) begin
      errors++; $display("FAIL txn_timeout: got %0d beats, want %0d and done", k, nb);
      if_req = 1'b0; dm_req = 1'b0;
    end
    mem_busy = 1'b0;
    @(negedge clock); #1;
    checks++;
    if ({if_done, dm_done, if_rvalid, dm_rvalid} !== 4'b0000) begin
      errors++; $display("FAIL done_once: got %b want 0000", {if_done, dm_done, if_rvalid, dm_rvalid});
    end
  endtask

  task automatic test_write_burst();
    run_txn(1'b1, 1'b0, 32'h8002_0010, 2'b01, 0, -1, 0);
  endtask

  task automatic test_arbitration();
    bit prefer_dm, exp_dm, seen;
    reset = 1'b1;
    @(negedge clock); @(negedge clock);
    reset = 1'b0; mem_busy = 1'b0;
    prefer_dm = 1'b1;
    if_req = 1'b1; if_addr = 32'h0000_1000; if_size = 2'b00;
    dm_req = 1'b1; dm_addr = 32'h0000_2000; dm_size = 2'b00; dm_rw = 1'b1;
    for (int n = 0; n < 4; n++) begin
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clock); #1;
        if (if_gnt === 1'b1 || dm_gnt === 1'b1) seen = 1'b1;
      end
      exp_dm = RR ? prefer_dm : 1'b1;
      checks++;
      if (!seen || {if_gnt, dm_gnt} !== {!exp_dm, exp_dm}) begin
        errors++; $display("FAIL arb_order[%0d]: got if_gnt=%b dm_gnt=%b want %b %b", n, if_gnt, dm_gnt, !exp_dm, exp_dm);
      end
      prefer_dm = (if_gnt === 1'b1);
    end
    if_req = 1'b0; dm_req = 1'b0;
    repeat (5) @(negedge clock);
  endtask

  task automatic test_busy_read();
    run_txn(1'b1, 1'b1, 32'h8002_0100, 2'b10, 0, 3, 2);
    run_txn(1'b0, 1'b1, 32'h0040_0200, 2'b10, 0, 3, 2);
  endtask

  task automatic test_wrap_read();
    run_txn(1'b1, 1'b1, 32'hFFFF_FFF8, 2'b01, 0, -1, 0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] base;
    logic [106:0] outs;
    bit seen;
    base = 32'h1000_0000; seen = 1'b0;
    @(negedge clock);
    mem_busy = 1'b0; dm_req = 1'b1; dm_addr = base; dm_size = 2'b11; dm_rw = 1'b1;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clock); #1;
      if (dm_gnt === 1'b1) seen = 1'b1;
    end
    dm_req = 1'b0;
    @(negedge clock);
    @(negedge clock); #1;
    checks++;
    if (!seen || mem_address !== base + 32'd8) begin
      errors++; $display("FAIL mid_beat2: got gnt_seen=%b addr=%h want 1 %h", seen, mem_address, base + 32'd8);
    end
    reset = 1'b1;
    @(negedge clock); #1;
    outs = {if_gnt, if_rvalid, if_done, dm_gnt, dm_wready, dm_rvalid, dm_done,
            rdata, mem_address, mem_data_in, mem_access_size, mem_rw, mem_enable};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL mid_reset_outputs: got %h want 0", outs); end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); #1;
      checks++;
      if ({dm_done, dm_rvalid, mem_enable} !== 3'b000) begin
        errors++; $display("FAIL mid_abandon: got done=%b rv=%b en=%b want 0 0 0", dm_done, dm_rvalid, mem_enable);
      end
    end
  endtask

  task automatic test_random();
    bit dm, rw;
    logic [31:0] base;
    for (int t = 0; t < 30; t++) begin
      dm   = 1'($urandom_range(1));
      rw   = dm ? 1'($urandom_range(1)) : 1'b1;
      base = {$urandom() >> 2, 2'b00};
      if ($urandom_range(3) == 0) base = 32'hFFFF_FFC0 | {26'd0, base[5:2], 2'b00};
      run_txn(dm, rw, base, 2'($urandom_range(3)), 25, -1, 0);
      repeat ($urandom_range(2)) @(negedge clock);
    end
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_rw = 1'b1; mem_busy = 1'b0;
    if_addr = 32'd0; dm_addr = 32'd0; if_size = 2'b00; dm_size = 2'b00; dm_wdata = 32'd0;
    test_reset();
    test_single_fetch();
    test_write_burst();
    test_arbitration();
    test_busy_read();
    test_wrap_read();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
